// File: rtl/dvi_pkg.sv
// Shared types and default timing for the DVI stream scheduler.
//   state_t : scheduler states (STOP, ARM, RUN, DRAIN)
//   pixel_t : 24-bit pixel {r, g, b}
//   DEF_*   : default 640x480 @ 60 Hz timing
package dvi_pkg;

  typedef enum logic [1:0] {
    STOP  = 2'd0,
    ARM   = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int DEF_H_RES  = 640;
  localparam int DEF_H_FP   = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP   = 48;
  localparam int DEF_V_RES  = 480;
  localparam int DEF_V_FP   = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP   = 33;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

endpackage

// File: rtl/dvi_timing_counter.sv
// Free-running pixel position counters with sync window decode.
//   clk, rst          : pixel clock, synchronous active-high reset
//   sx, sy            : current pixel position (unsigned, clog2 width)
//   active            : position lies inside the visible area
//   hsync, vsync      : position lies inside the sync window (active-high, polarity applied by the caller)
//   eof               : last pixel of the frame
module dvi_timing_counter
  import dvi_pkg::*;
#(
  parameter int H_RES  = DEF_H_RES,
  parameter int H_FP   = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP   = DEF_H_BP,
  parameter int V_RES  = DEF_V_RES,
  parameter int V_FP   = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP   = DEF_V_BP,
  localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP,
  localparam int SXW = $clog2(H_TOTAL),
  localparam int SYW = $clog2(V_TOTAL)
) (
  input  logic           clk,
  input  logic           rst,
  output logic [SXW-1:0] sx,
  output logic [SYW-1:0] sy,
  output logic           active,
  output logic           hsync,
  output logic           vsync,
  output logic           eof
);

  // Window bounds are compared one bit wider so an end bound equal to the
  // total still fits when a back porch is zero.
  localparam logic [SXW:0]   H_ACT_END  = (SXW+1)'(H_RES);
  localparam logic [SXW:0]   H_SYNC_BEG = (SXW+1)'(H_RES + H_FP);
  localparam logic [SXW:0]   H_SYNC_END = (SXW+1)'(H_RES + H_FP + H_SYNC);
  localparam logic [SYW:0]   V_ACT_END  = (SYW+1)'(V_RES);
  localparam logic [SYW:0]   V_SYNC_BEG = (SYW+1)'(V_RES + V_FP);
  localparam logic [SYW:0]   V_SYNC_END = (SYW+1)'(V_RES + V_FP + V_SYNC);
  localparam logic [SXW-1:0] H_LAST     = SXW'(H_TOTAL - 1);
  localparam logic [SYW-1:0] V_LAST     = SYW'(V_TOTAL - 1);

  logic [SXW:0] sx_w;
  logic [SYW:0] sy_w;

  always_ff @(posedge clk) begin
    if (rst) begin
      sx <= '0;
      sy <= '0;
    end else if (sx == H_LAST) begin
      sx <= '0;
      sy <= (sy == V_LAST) ? '0 : sy + SYW'(1);
    end else begin
      sx <= sx + SXW'(1);
    end
  end

  assign sx_w   = {1'b0, sx};
  assign sy_w   = {1'b0, sy};
  assign active = (sx_w < H_ACT_END) && (sy_w < V_ACT_END);
  assign hsync  = (sx_w >= H_SYNC_BEG) && (sx_w < H_SYNC_END);
  assign vsync  = (sy_w >= V_SYNC_BEG) && (sy_w < V_SYNC_END);
  assign eof    = (sx == H_LAST) && (sy == V_LAST);

endmodule

// File: rtl/dvi_stream_sched.sv
// DVI stream scheduler: runs pixel timing, gates active video on frame
// boundaries and pulls pixels from an upstream ready/valid source.
//   clk_pix, rst_pix          : pixel clock, synchronous active-high reset
//   enable                    : level request for active video
//   pix_valid, pix_data       : upstream pixel {R,G,B}; pix_ready accepts it
//   de, data_ch0..2           : data enable and B/G/R to the DVI generator
//   ctrl_ch0                  : {vsync, hsync}; ctrl_ch1/ctrl_ch2 tied to 0
//   frame_start, line_start   : pulses on output pixel (0,0) / sx = 0
//   underflow, underflow_clr  : sticky starvation flag and its clear
// Build option DVI_STREAM_SCHED_PATTERN_EN: starved pixels show an 8-bar
// colour pattern instead of black.
module dvi_stream_sched
  import dvi_pkg::*;
#(
  parameter int H_RES    = DEF_H_RES,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_RES    = DEF_V_RES,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        clk_pix,
  input  logic        rst_pix,
  input  logic        enable,
  input  logic        pix_valid,
  input  logic [23:0] pix_data,
  output logic        pix_ready,
  output logic        de,
  output logic [7:0]  data_ch0,
  output logic [7:0]  data_ch1,
  output logic [7:0]  data_ch2,
  output logic [1:0]  ctrl_ch0,
  output logic [1:0]  ctrl_ch1,
  output logic [1:0]  ctrl_ch2,
  output logic        frame_start,
  output logic        line_start,
  output logic        underflow,
  input  logic        underflow_clr
);

  localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;
  localparam int SXW     = $clog2(H_TOTAL);
  localparam int SYW     = $clog2(V_TOTAL);

  logic [SXW-1:0] sx_p0;
  logic [SYW-1:0] sy_p0;
  logic           active_p0, hsync_p0, vsync_p0, eof_p0;
  state_t         state;
  pixel_t         in_pix_p0, fallback_p0;

  logic           de_p1, fs_p1, ls_p1, underflow_p1;
  pixel_t         pix_p1;
  logic [1:0]     ctrl_p1;

  dvi_timing_counter #(
    .H_RES (H_RES), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_RES (V_RES), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
  ) u_timing (
    .clk    (clk_pix),
    .rst    (rst_pix),
    .sx     (sx_p0),
    .sy     (sy_p0),
    .active (active_p0),
    .hsync  (hsync_p0),
    .vsync  (vsync_p0),
    .eof    (eof_p0)
  );

`ifdef DVI_STREAM_SCHED_PATTERN_EN
  function automatic pixel_t bar_pixel(input logic [SXW-1:0] x);
    int unsigned bar;
    pixel_t      p;
    bar = (32'(x) * 32'd8) / 32'(H_RES);
    p.r = bar[0] ? 8'hFF : 8'h00;
    p.g = bar[1] ? 8'hFF : 8'h00;
    p.b = bar[2] ? 8'hFF : 8'h00;
    return p;
  endfunction

  assign fallback_p0 = bar_pixel(sx_p0);
`else
  assign fallback_p0 = '0;
`endif

  // ---- stage p0: scheduler state and upstream handshake ----
  // Video only opens at the EOF -> (0,0) transition (ARM -> RUN) and only
  // closes at EOF (DRAIN -> STOP), so a frame is never cut short.
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      state <= STOP;
    end else begin
      unique case (state)
        STOP:    if (enable) state <= ARM;
        ARM:     if (!enable) state <= STOP;
                 else if (eof_p0) state <= RUN;
        RUN:     if (!enable) state <= DRAIN;
        DRAIN:   if (enable) state <= RUN;
                 else if (eof_p0) state <= STOP;
        default: state <= STOP;
      endcase
    end
  end

  assign pix_ready = ((state == RUN) || (state == DRAIN)) && active_p0;
  assign in_pix_p0 = pix_data;

  // ---- stage p1: registered DVI generator inputs ----
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      de_p1        <= 1'b0;
      pix_p1       <= '0;
      ctrl_p1      <= {~SYNC_POL, ~SYNC_POL};
      fs_p1        <= 1'b0;
      ls_p1        <= 1'b0;
      underflow_p1 <= 1'b0;
    end else begin
      de_p1   <= pix_ready;
      pix_p1  <= !pix_ready ? '0 : (pix_valid ? in_pix_p0 : fallback_p0);
      ctrl_p1 <= {vsync_p0 ? SYNC_POL : ~SYNC_POL,
                  hsync_p0 ? SYNC_POL : ~SYNC_POL};
      fs_p1   <= (sx_p0 == '0) && (sy_p0 == '0);
      ls_p1   <= (sx_p0 == '0);
      // A starved pixel outranks a clear in the same cycle.
      if (pix_ready && !pix_valid) underflow_p1 <= 1'b1;
      else if (underflow_clr)      underflow_p1 <= 1'b0;
    end
  end

  assign de          = de_p1;
  assign data_ch0    = pix_p1.b;
  assign data_ch1    = pix_p1.g;
  assign data_ch2    = pix_p1.r;
  assign ctrl_ch0    = ctrl_p1;
  assign ctrl_ch1    = 2'b00;
  assign ctrl_ch2    = 2'b00;
  assign frame_start = fs_p1;
  assign line_start  = ls_p1;
  assign underflow   = underflow_p1;

endmodule

// File: tb/tb_dvi_stream_sched.sv
// Testbench for dvi_stream_sched using a reduced 16x8 raster so whole frames
// fit in a short run. A position/mode model derived from the timing rules
// predicts every registered output one cycle ahead.
module tb_dvi_stream_sched;

  localparam int HR = 16, HF = 2, HS = 4, HB = 3;
  localparam int VR = 8,  VF = 2, VS = 2, VB = 3;
  localparam int HT = HR + HF + HS + HB;
  localparam int VT = VR + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int M_STOP = 0, M_ARM = 1, M_RUN = 2, M_DRAIN = 3;

  logic clk = 1'b0;
  logic rst, en, vld, clr;
  logic [23:0] dat;
  logic pix_ready, de, frame_start, line_start, underflow;
  logic [7:0] data_ch0, data_ch1, data_ch2;
  logic [1:0] ctrl_ch0, ctrl_ch1, ctrl_ch2;

  int checks, errors;
  int mpos, mode;
  logic e_de, e_fs, e_ls, e_uf;
  logic [23:0] e_pix;
  logic [1:0] e_ctrl;

  always #5 clk = ~clk;

  dvi_stream_sched #(
    .H_RES (HR), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_RES (VR), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .SYNC_POL (1'b0)
  ) dut (
    .clk_pix       (clk),
    .rst_pix       (rst),
    .enable        (en),
    .pix_valid     (vld),
    .pix_data      (dat),
    .pix_ready     (pix_ready),
    .de            (de),
    .data_ch0      (data_ch0),
    .data_ch1      (data_ch1),
    .data_ch2      (data_ch2),
    .ctrl_ch0      (ctrl_ch0),
    .ctrl_ch1      (ctrl_ch1),
    .ctrl_ch2      (ctrl_ch2),
    .frame_start   (frame_start),
    .line_start    (line_start),
    .underflow     (underflow),
    .underflow_clr (clr)
  );

  function automatic logic [23:0] fallback(input int x);
    int bar;
    bar = (x * 8) / HR;
`ifdef DVI_STREAM_SCHED_PATTERN_EN
    return {bar[0] ? 8'hFF : 8'h00, bar[1] ? 8'hFF : 8'h00, bar[2] ? 8'hFF : 8'h00};
`else
    return (bar < 0) ? 24'hFFFFFF : 24'h000000;
`endif
  endfunction

  function automatic logic m_ready();
    int x, y;
    x = mpos % HT;
    y = mpos / HT;
    return ((mode == M_RUN) || (mode == M_DRAIN)) && (x < HR) && (y < VR);
  endfunction

  // Advance model and DUT by one clock; expectations describe the outputs
  // visible after the edge.
  task automatic tick();
    int x, y;
    logic rdy, hs_on, vs_on, eof;
    if (rst) begin
      mpos = 0; mode = M_STOP;
      e_de = 0; e_pix = 0; e_ctrl = 2'b11; e_fs = 0; e_ls = 0; e_uf = 0;
    end else begin
      x = mpos % HT;
      y = mpos / HT;
      rdy = m_ready();
      hs_on = (x >= HR + HF) && (x < HR + HF + HS);
      vs_on = (y >= VR + VF) && (y < VR + VF + VS);
      e_de = rdy;
      e_pix = !rdy ? 24'h0 : (vld ? dat : fallback(x));
      e_ctrl = {~vs_on, ~hs_on};
      e_fs = (mpos == 0);
      e_ls = (x == 0);
      if (rdy && !vld) e_uf = 1;
      else if (clr) e_uf = 0;
      eof = (mpos == FRAME - 1);
      if (mode == M_STOP) begin
        if (en) mode = M_ARM;
      end else if (mode == M_ARM) begin
        if (!en) mode = M_STOP; else if (eof) mode = M_RUN;
      end else if (mode == M_RUN) begin
        if (!en) mode = M_DRAIN;
      end else begin
        if (en) mode = M_RUN; else if (eof) mode = M_STOP;
      end
      mpos = (mpos + 1) % FRAME;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pos(input int target);
    int n = 0;
    while (mpos != target && n < 2 * FRAME) begin
      tick();
      n++;
    end
    checks++;
    if (mpos != target) begin
      errors++;
      $display("FAIL wait_pos: position %0d reached instead of %0d", mpos, target);
    end
  endtask

  task automatic test_reset();
    en = 1; vld = 1; dat = $urandom;
    tick();
    wait_pos(0);
    wait_pos(2 * HT + 5);
    vld = 0;
    tick();
    vld = 1;
    checks++;
    if (underflow !== 1'b1) begin errors++; $display("FAIL reset_pre_uf: got %b want 1", underflow); end
    rst = 1;
    tick();
    checks++;
    if (de !== 1'b0 || {data_ch2, data_ch1, data_ch0} !== 24'h0) begin
      errors++; $display("FAIL reset_hold: de=%b data=%h want 0/0", de, {data_ch2, data_ch1, data_ch0});
    end
    tick(); tick();
    rst = 0;
    checks++;
    if (pix_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_pre: got %b want 0", pix_ready); end
    tick();
    checks++;
    if (de !== 1'b0) begin errors++; $display("FAIL reset_de: got %b want 0", de); end
    checks++;
    if (ctrl_ch0 !== 2'b11) begin errors++; $display("FAIL reset_ctrl: got %b want 11", ctrl_ch0); end
    checks++;
    if (pix_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", pix_ready); end
    checks++;
    if (underflow !== 1'b0) begin errors++; $display("FAIL reset_uf: got %b want 0", underflow); end
    checks++;
    if (frame_start !== 1'b1) begin errors++; $display("FAIL reset_fs: got %b want 1", frame_start); end
    checks++;
    if (ctrl_ch1 !== 2'b00 || ctrl_ch2 !== 2'b00) begin
      errors++; $display("FAIL ctrl_tied: got %b/%b want 00/00", ctrl_ch1, ctrl_ch2);
    end
    en = 0;
  endtask

  task automatic test_sync();
    int n = 0, hcnt = 0, vcnt = 0, x, y;
    logic hlow, vlow;
    en = 0;
    while (mode != M_STOP && n < 3 * FRAME) begin tick(); n++; end
    wait_pos(0);
    for (int k = 0; k < FRAME; k++) begin
      tick();
      x = k % HT; y = k / HT;
      hlow = (x >= HR + HF) && (x < HR + HF + HS);
      vlow = (y >= VR + VF) && (y < VR + VF + VS);
      hcnt += (ctrl_ch0[0] == 1'b0) ? 1 : 0;
      vcnt += (ctrl_ch0[1] == 1'b0) ? 1 : 0;
      checks++;
      if (ctrl_ch0 !== {~vlow, ~hlow}) begin
        errors++; $display("FAIL sync_ctrl k=%0d: got %b want %b", k, ctrl_ch0, {~vlow, ~hlow});
      end
      checks++;
      if (de !== 1'b0) begin errors++; $display("FAIL sync_de k=%0d: got %b want 0", k, de); end
      checks++;
      if (frame_start !== (k == 0) || line_start !== (x == 0)) begin
        errors++; $display("FAIL sync_pulses k=%0d: fs=%b ls=%b want %b %b", k, frame_start, line_start, k == 0, x == 0);
      end
    end
    checks++;
    if (hcnt != HS * VT) begin errors++; $display("FAIL sync_hcount: got %0d want %0d", hcnt, HS * VT); end
    checks++;
    if (vcnt != VS * HT) begin errors++; $display("FAIL sync_vcount: got %0d want %0d", vcnt, VS * HT); end
  endtask

  task automatic test_start();
    int n = 0, early = 0, total = 0, bad = 0;
    int linecnt[VT];
    logic found = 0;
    foreach (linecnt[i]) linecnt[i] = 0;
    wait_pos(3 * HT);
    en = 1;
    while (!found && n < 2 * FRAME) begin
      vld = ($urandom % 4) != 0; dat = $urandom;
      tick();
      n++;
      if (frame_start) found = 1;
      else if (de) early++;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL start_fs: no frame_start within %0d cycles", n); end
    checks++;
    if (early != 0) begin errors++; $display("FAIL start_early_de: got %0d de cycles want 0", early); end
    for (int k = 0; k < FRAME; k++) begin
      if (k > 0) begin
        vld = ($urandom % 4) != 0; dat = $urandom;
        tick();
      end
      linecnt[k / HT] += de ? 1 : 0;
      total += de ? 1 : 0;
      checks++;
      if (de !== e_de || {data_ch2, data_ch1, data_ch0} !== e_pix) begin
        errors++; $display("FAIL start_pix k=%0d: de=%b data=%h want %b %h", k, de, {data_ch2, data_ch1, data_ch0}, e_de, e_pix);
      end
    end
    for (int l = 0; l < VT; l++) if (linecnt[l] != ((l < VR) ? HR : 0)) bad++;
    checks++;
    if (total != HR * VR) begin errors++; $display("FAIL start_total: got %0d want %0d", total, HR * VR); end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL start_lines: %0d lines with wrong de count want 0", bad); end
  endtask

  task automatic test_handshake();
    int px, py, cnt = 0;
    vld = 1; clr = 1;
    tick();
    clr = 0;
    wait_pos(0);
    for (int k = 0; k < FRAME; k++) begin
      px = mpos % HT; py = mpos / HT;
      dat = {8'(py), 8'(px), 8'h5A};
      tick();
      checks++;
      if (de !== e_de) begin errors++; $display("FAIL hs_de k=%0d: got %b want %b", k, de, e_de); end
      if (e_de) begin
        cnt++;
        checks++;
        if (data_ch0 !== 8'h5A || data_ch1 !== 8'(px) || data_ch2 !== 8'(py)) begin
          errors++; $display("FAIL hs_data (%0d,%0d): got %h %h %h want 5a %h %h", px, py, data_ch0, data_ch1, data_ch2, 8'(px), 8'(py));
        end
      end
    end
    checks++;
    if (cnt != HR * VR || underflow !== 1'b0) begin
      errors++; $display("FAIL hs_frame: accepted=%0d uf=%b want %0d 0", cnt, underflow, HR * VR);
    end
  endtask

  task automatic test_underflow();
    vld = 1; clr = 0;
    wait_pos(2 * HT + 1);
    vld = 0;
    tick();
    vld = 1;
    checks++;
    if (de !== 1'b1 || {data_ch2, data_ch1, data_ch0} !== 24'h0) begin
      errors++; $display("FAIL uf_pixel: de=%b data=%h want 1 000000", de, {data_ch2, data_ch1, data_ch0});
    end
    checks++;
    if (underflow !== 1'b1) begin errors++; $display("FAIL uf_set: got %b want 1", underflow); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (underflow !== 1'b1) begin errors++; $display("FAIL uf_sticky %0d: got %b want 1", i, underflow); end
    end
    wait_pos(3 * HT + 1);
    vld = 0; clr = 1;
    tick();
    checks++;
    if (underflow !== 1'b1) begin errors++; $display("FAIL uf_set_wins: got %b want 1", underflow); end
    vld = 1;
    tick();
    clr = 0;
    checks++;
    if (underflow !== 1'b0) begin errors++; $display("FAIL uf_clear: got %b want 0", underflow); end
    tick();
    checks++;
    if (underflow !== 1'b0) begin errors++; $display("FAIL uf_stays_clear: got %b want 0", underflow); end
    wait_pos(4 * HT + 10);
    vld = 0;
    tick();
    vld = 1;
    checks++;
    if ({data_ch2, data_ch1, data_ch0} !== fallback(10) || de !== 1'b1) begin
      errors++; $display("FAIL uf_fallback: de=%b data=%h want 1 %h", de, {data_ch2, data_ch1, data_ch0}, fallback(10));
    end
    clr = 1;
    tick();
    clr = 0;
  endtask

  task automatic test_drain();
    int s1 = 0, s2 = 0, s3 = 0, s4 = 0;
    vld = 1; en = 1;
    wait_pos(0);
    for (int k = 0; k < FRAME; k++) begin
      if (mpos == 4 * HT) en = 0;
      tick(); s1 += de ? 1 : 0;
    end
    for (int k = 0; k < FRAME; k++) begin tick(); s2 += de ? 1 : 0; end
    checks++;
    if (s1 != HR * VR) begin errors++; $display("FAIL drain_frame: got %0d want %0d", s1, HR * VR); end
    checks++;
    if (s2 != 0) begin errors++; $display("FAIL drain_after: got %0d want 0", s2); end
    en = 1;
    tick();
    wait_pos(0);
    for (int k = 0; k < FRAME; k++) begin
      if (mpos == 4 * HT) en = 0;
      if (mpos == 6 * HT) en = 1;
      tick(); s3 += de ? 1 : 0;
    end
    for (int k = 0; k < FRAME; k++) begin tick(); s4 += de ? 1 : 0; end
    checks++;
    if (s3 != HR * VR) begin errors++; $display("FAIL redrain_frame: got %0d want %0d", s3, HR * VR); end
    checks++;
    if (s4 != HR * VR) begin errors++; $display("FAIL redrain_next: got %0d want %0d", s4, HR * VR); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if (($urandom % 150) == 0) en = ~en;
      vld = ($urandom % 10) != 0;
      clr = ($urandom % 20) == 0;
      rst = ($urandom % 1000) == 0;
      dat = $urandom;
      checks++;
      if (pix_ready !== m_ready()) begin errors++; $display("FAIL rnd_ready %0d: got %b want %b", i, pix_ready, m_ready()); end
      tick();
      checks++;
      if (de !== e_de || {data_ch2, data_ch1, data_ch0} !== e_pix) begin
        errors++; $display("FAIL rnd_pix %0d: de=%b data=%h want %b %h", i, de, {data_ch2, data_ch1, data_ch0}, e_de, e_pix);
      end
      checks++;
      if (ctrl_ch0 !== e_ctrl || frame_start !== e_fs || line_start !== e_ls) begin
        errors++; $display("FAIL rnd_ctrl %0d: ctrl=%b fs=%b ls=%b want %b %b %b", i, ctrl_ch0, frame_start, line_start, e_ctrl, e_fs, e_ls);
      end
      checks++;
      if (underflow !== e_uf) begin errors++; $display("FAIL rnd_uf %0d: got %b want %b", i, underflow, e_uf); end
    end
    rst = 0; clr = 0;
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1; en = 0; vld = 0; clr = 0; dat = 24'h0;
    mpos = 0; mode = M_STOP;
    e_de = 0; e_pix = 0; e_ctrl = 2'b11; e_fs = 0; e_ls = 0; e_uf = 0;
    tick(); tick();
    rst = 0;
    test_reset();
    test_sync();
    test_start();
    test_handshake();
    test_underflow();
    test_drain();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
